// File: rtl/systolic_array_linebuffer3.sv
// Three-row line buffer feeding the 3x3 kernel cells: turns a raster pixel stream
// into vertical columns {row r-2, row r-1, row r} for every pixel of rows r>=2.
module systolic_array_linebuffer3 #(
    parameter int data_width = 8,
    parameter int img_width  = 64,
    parameter int img_height = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] in_pix,
    input  logic                  in_val,
    input  logic                  in_sof,
    output logic                  in_rdy,
    output logic [data_width-1:0] x1,
    output logic                  x1_val,
    output logic [data_width-1:0] x2,
    output logic                  x2_val,
    output logic [data_width-1:0] x3,
    output logic                  x3_val,
    output logic                  new_row,
    output logic                  frame_done
);
    localparam int CW = $clog2(img_width);
    localparam int RW = $clog2(img_height);

    typedef enum logic [1:0] {FILL0, FILL1, STREAM} state_t;

    state_t                    state;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic [2*data_width-1:0]   mem [img_width];
    logic [2*data_width-1:0]   rd;
    logic [data_width-1:0]     t1, t2;
    logic [CW-1:0]             wr_addr;
    logic                      accept, col_last, row_last, emit;
    logic                      vld;

    assign in_rdy   = reset;
    assign accept   = in_val & reset;
    assign col_last = (col == CW'(img_width - 1));
    assign row_last = (row == RW'(img_height - 1));
    // A start-of-frame beat is pixel (0,0) no matter where the counters are.
    assign wr_addr  = in_sof ? '0 : col;
    assign rd       = mem[wr_addr];
    assign t2       = rd[2*data_width-1:data_width];
    assign t1       = rd[data_width-1:0];
    assign emit     = accept && !in_sof && (state == STREAM);

    assign x1_val = vld;
    assign x2_val = vld;
    assign x3_val = vld;

    // Line memory carries no reset: the two fill rows overwrite every entry before use.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_addr] <= {t1, in_pix};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL0;
            col        <= '0;
            row        <= '0;
            x1         <= '0;
            x2         <= '0;
            x3         <= '0;
            vld        <= 1'b0;
            new_row    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vld        <= emit;
            new_row    <= emit && (col == '0);
            frame_done <= emit && col_last && row_last;
            if (accept) begin
                x1 <= t2;
                x2 <= t1;
                x3 <= in_pix;
                if (in_sof) begin
                    col   <= CW'(1);
                    row   <= '0;
                    state <= FILL0;
                end else begin
                    col <= col_last ? '0 : col + CW'(1);
                    if (col_last) begin
                        row <= row_last ? '0 : row + RW'(1);
                        case (state)
                            FILL0:   state <= FILL1;
                            FILL1:   state <= STREAM;
                            STREAM:  if (row_last) state <= FILL0;
                            default: state <= FILL0;
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_array_linebuffer3.sv
// Scoreboard bench: the driver models frames as a 2-D pixel array and queues one
// expectation per accepted beat; the monitor checks the registered outputs.
module tb_systolic_array_linebuffer3;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_pix;
    logic          in_val, in_sof, in_rdy;
    logic [DW-1:0] x1, x2, x3;
    logic          x1_val, x2_val, x3_val, new_row, frame_done;

    systolic_array_linebuffer3 #(.data_width(DW), .img_width(W), .img_height(H)) dut (
        .clk(clk), .reset(reset), .in_pix(in_pix), .in_val(in_val), .in_sof(in_sof),
        .in_rdy(in_rdy), .x1(x1), .x1_val(x1_val), .x2(x2), .x2_val(x2_val),
        .x3(x3), .x3_val(x3_val), .new_row(new_row), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          val;
        logic [DW-1:0] x1, x2, x3;
        logic          nr, fd;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] img [H][W];
    int            mr, mc;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [DW-1:0] p, input logic sof);
        exp_t e;
        @(negedge clk);
        in_val = 1'b1; in_pix = p; in_sof = sof;
        if (sof) begin mr = 0; mc = 0; end
        e.val = (mr >= 2);
        e.x1 = '0; e.x2 = '0; e.x3 = p;
        if (e.val) begin
            e.x1 = img[mr-2][mc];
            e.x2 = img[mr-1][mc];
        end
        e.nr = e.val && (mc == 0);
        e.fd = e.val && (mr == H-1) && (mc == W-1);
        img[mr][mc] = p;
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end
        q.push_back(e);
    endtask

    // Idle beats also toggle in_sof, which must be ignored without in_val.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_val = 1'b0;
            in_sof = 1'(($urandom & 32'h1));
            in_pix = DW'($urandom);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, in_rdy, 0);
        chk({tag, "_val"}, {x1_val, x2_val, x3_val}, 0);
        chk({tag, "_x"}, {x1, x2, x3}, 0);
        chk({tag, "_pulse"}, {new_row, frame_done}, 0);
    endtask

    // Monitor: one queued expectation per beat accepted at the previous edge.
    logic          acc_q;
    logic [DW-1:0] px1, px2, px3;

    always @(posedge clk or negedge reset) begin
        if (!reset) acc_q <= 1'b0;
        else        acc_q <= in_val;
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            px1 = '0; px2 = '0; px3 = '0;
        end else begin
            if (acc_q) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("x1_val", x1_val, e.val);
                    chk("x2_val", x2_val, e.val);
                    chk("x3_val", x3_val, e.val);
                    chk("new_row", new_row, e.nr);
                    chk("frame_done", frame_done, e.fd);
                    if (e.val) begin
                        chk("x1", x1, e.x1);
                        chk("x2", x2, e.x2);
                        chk("x3", x3, e.x3);
                    end
                end
            end else begin
                chk("idle_val", {x1_val, x2_val, x3_val}, 0);
                chk("idle_pulse", {new_row, frame_done}, 0);
                chk("hold_x", {x1, x2, x3}, {px1, px2, px3});
            end
            px1 = x1; px2 = x2; px3 = x3;
        end
    end

    initial begin
        reset = 1'b0; in_val = 1'b0; in_sof = 1'b0; in_pix = '0;
        mr = 0; mc = 0;
        #3 chk_zero("reset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rdy_after_reset", in_rdy, 1);

        // Frame of row*16+col with an idle gap mid-row inside the streaming part.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(DW'(r*16 + c), 1'b0);
                if (r == 2 && c == 1) idle(3);
            end

        // Abandon a frame at row 2 col 1 with a start-of-frame beat.
        for (int i = 0; i < 9; i++) send(DW'(8'h40 + i), 1'b0);
        send(8'hA0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            send(DW'($urandom), 1'b0);
            if (($urandom % 3) == 0) idle(1 + int'($urandom % 3));
        end

        // Random traffic with sporadic start-of-frame beats.
        for (int i = 0; i < 300; i++) begin
            if (($urandom % 4) == 0) idle(1);
            else send(DW'($urandom), 1'(($urandom % 40) == 0));
        end

        // Async reset while streaming, asserted between clock edges.
        send(DW'($urandom), 1'b1);
        for (int i = 0; i < 10; i++) send(DW'($urandom), 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        q.delete();
        mr = 0; mc = 0;
        in_val = 1'b0; in_sof = 1'b0;
        #1 chk_zero("async_reset");
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rdy_after_release", in_rdy, 1);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) send(DW'(8'h80 + r*16 + c), 1'b0);
        idle(3);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
